// File: rtl/ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_register
// Purpose  : EX->MEM pipeline register of the 5-stage MIPS core. Captures the
//            ALU result, zero flag and execute-stage control. Resolves the
//            branch decision, byte enables, store-lane replication and
//            misalignment at capture time. Provides stall/flush, a sticky
//            HALT flag and a saturating retired-instruction counter.
// Ports    : i_clk, i_rst_n (async, active low)
//            i_stall / i_flush         pipeline control (flush wins)
//            i_valid + EX-stage fields  instruction being captured
//            o_*                        registered MEM-stage view
//            o_halted, o_retired_count  debug-unit status
// Revision : 1.0  initial release
// ============================================================================
module ex_mem_register #(
  parameter int NB     = 32,
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [NB-1:0]     i_alu_result,
  input  logic              i_alu_zero,
  input  logic [NB-1:0]     i_rt_data,
  input  logic [NB_REG-1:0] i_rd_addr,
  input  logic [NB-1:0]     i_pc_plus4,
  input  logic [NB-1:0]     i_branch_target,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic              i_branch_eq,
  input  logic              i_branch_ne,
  input  logic [1:0]        i_mem_width,
  input  logic              i_mem_unsigned,
  input  logic              i_halt,
  output logic              o_valid,
  output logic [NB-1:0]     o_alu_result,
  output logic [NB-1:0]     o_store_data,
  output logic [3:0]        o_byte_en,
  output logic [NB_REG-1:0] o_rd_addr,
  output logic [NB-1:0]     o_pc_plus4,
  output logic [NB-1:0]     o_branch_target,
  output logic              o_branch_taken,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic [1:0]        o_mem_width,
  output logic              o_mem_unsigned,
  output logic              o_misaligned,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_retired_count
);

  localparam logic [1:0]        c_w_byte    = 2'b00;
  localparam logic [1:0]        c_w_half    = 2'b01;
  localparam logic [NB_CNT-1:0] c_cnt_max   = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] c_cnt_one   = {{(NB_CNT-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic              valid_q,         valid_d;
  logic [NB-1:0]     alu_result_q,    alu_result_d;
  logic [NB-1:0]     store_data_q,    store_data_d;
  logic [3:0]        byte_en_q,       byte_en_d;
  logic [NB_REG-1:0] rd_addr_q,       rd_addr_d;
  logic [NB-1:0]     pc_plus4_q,      pc_plus4_d;
  logic [NB-1:0]     branch_target_q, branch_target_d;
  logic              branch_taken_q,  branch_taken_d;
  logic              mem_read_q,      mem_read_d;
  logic              mem_write_q,     mem_write_d;
  logic              reg_write_q,     reg_write_d;
  logic              mem_to_reg_q,    mem_to_reg_d;
  logic [1:0]        mem_width_q,     mem_width_d;
  logic              mem_unsigned_q,  mem_unsigned_d;
  logic              misaligned_q,    misaligned_d;
  logic              halted_q,        halted_d;
  logic [NB_CNT-1:0] retired_q,       retired_d;

  // --------------------------------------------------------------------------
  // Capture-time decode of the EX-stage instruction
  // --------------------------------------------------------------------------
  logic [1:0]    w_addr;
  logic          w_mem_op;
  logic [3:0]    w_lane_be;
  logic [NB-1:0] w_store_data;
  logic          w_misaligned;
  logic          w_branch_taken;

  assign w_addr   = i_alu_result[1:0];
  assign w_mem_op = i_mem_read | i_mem_write;

  always_comb begin
    w_lane_be    = 4'b1111;
    w_store_data = i_rt_data;
    w_misaligned = 1'b0;
    case (i_mem_width)
      c_w_byte: begin
        w_lane_be    = 4'b0001 << w_addr;
        w_store_data = {4{i_rt_data[7:0]}};
      end
      c_w_half: begin
        w_lane_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{i_rt_data[15:0]}};
        w_misaligned = w_mem_op & w_addr[0];
      end
      // word and the reserved encoding both behave as a full word access
      default: begin
        w_lane_be    = 4'b1111;
        w_store_data = i_rt_data;
        w_misaligned = w_mem_op & (w_addr != 2'b00);
      end
    endcase
  end

  // BEQ and BNE together is an illegal encoding and never branches.
  assign w_branch_taken = ~(i_branch_eq & i_branch_ne) &
                          ((i_branch_eq & i_alu_zero) | (i_branch_ne & ~i_alu_zero));

  // --------------------------------------------------------------------------
  // Next-state: flush > stall > capture. A halted stage only takes bubbles.
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d         = valid_q;
    alu_result_d    = alu_result_q;
    store_data_d    = store_data_q;
    byte_en_d       = byte_en_q;
    rd_addr_d       = rd_addr_q;
    pc_plus4_d      = pc_plus4_q;
    branch_target_d = branch_target_q;
    branch_taken_d  = branch_taken_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    mem_width_d     = mem_width_q;
    mem_unsigned_d  = mem_unsigned_q;
    misaligned_d    = misaligned_q;
    halted_d        = halted_q;
    retired_d       = retired_q;

    if (i_flush || (!i_stall && (halted_q || !i_valid))) begin
      // Bubble: everything cleared except the sticky halt and the counter
      valid_d         = 1'b0;
      alu_result_d    = '0;
      store_data_d    = '0;
      byte_en_d       = 4'b0000;
      rd_addr_d       = '0;
      pc_plus4_d      = '0;
      branch_target_d = '0;
      branch_taken_d  = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      reg_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
      mem_width_d     = 2'b00;
      mem_unsigned_d  = 1'b0;
      misaligned_d    = 1'b0;
    end else if (!i_stall) begin
      valid_d         = 1'b1;
      alu_result_d    = i_alu_result;
      store_data_d    = w_store_data;
      byte_en_d       = w_mem_op ? w_lane_be : 4'b0000;
      rd_addr_d       = i_rd_addr;
      pc_plus4_d      = i_pc_plus4;
      branch_target_d = i_branch_target;
      branch_taken_d  = w_branch_taken;
      // A misaligned access is suppressed but still retires; HALT writes nothing.
      mem_read_d      = i_mem_read  & ~w_misaligned;
      mem_write_d     = i_mem_write & ~w_misaligned & ~i_halt;
      reg_write_d     = i_reg_write & ~w_misaligned & ~i_halt;
      mem_to_reg_d    = i_mem_to_reg;
      mem_width_d     = i_mem_width;
      mem_unsigned_d  = i_mem_unsigned;
      misaligned_d    = w_misaligned;
      if (i_halt) begin
        halted_d = 1'b1;
      end else if (retired_q != c_cnt_max) begin
        retired_d = retired_q + c_cnt_one;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q         <= 1'b0;
      alu_result_q    <= '0;
      store_data_q    <= '0;
      byte_en_q       <= 4'b0000;
      rd_addr_q       <= '0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
      branch_taken_q  <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_width_q     <= 2'b00;
      mem_unsigned_q  <= 1'b0;
      misaligned_q    <= 1'b0;
      halted_q        <= 1'b0;
      retired_q       <= '0;
    end else begin
      valid_q         <= valid_d;
      alu_result_q    <= alu_result_d;
      store_data_q    <= store_data_d;
      byte_en_q       <= byte_en_d;
      rd_addr_q       <= rd_addr_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
      branch_taken_q  <= branch_taken_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      mem_width_q     <= mem_width_d;
      mem_unsigned_q  <= mem_unsigned_d;
      misaligned_q    <= misaligned_d;
      halted_q        <= halted_d;
      retired_q       <= retired_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_alu_result    = alu_result_q;
  assign o_store_data    = store_data_q;
  assign o_byte_en       = byte_en_q;
  assign o_rd_addr       = rd_addr_q;
  assign o_pc_plus4      = pc_plus4_q;
  assign o_branch_target = branch_target_q;
  assign o_branch_taken  = branch_taken_q;
  assign o_mem_read      = mem_read_q;
  assign o_mem_write     = mem_write_q;
  assign o_reg_write     = reg_write_q;
  assign o_mem_to_reg    = mem_to_reg_q;
  assign o_mem_width     = mem_width_q;
  assign o_mem_unsigned  = mem_unsigned_q;
  assign o_misaligned    = misaligned_q;
  assign o_halted        = halted_q;
  assign o_retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_register
// Purpose  : Self-checking bench for ex_mem_register. Random and directed
//            stimulus is compared every cycle against a behavioural model of
//            the stage. The counter is narrowed to 4 bits so saturation is
//            reachable in a short run.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_register;

  localparam int NB_CNT = 4;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, valid;
  logic [31:0] alu_result, rt_data, pc_plus4, branch_target;
  logic        alu_zero;
  logic [4:0]  rd_addr;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic        branch_eq, branch_ne, mem_unsigned, halt;
  logic [1:0]  mem_width;

  logic        o_valid, o_branch_taken, o_mem_read, o_mem_write, o_reg_write;
  logic        o_mem_to_reg, o_mem_unsigned, o_misaligned, o_halted;
  logic [31:0] o_alu_result, o_store_data, o_pc_plus4, o_branch_target;
  logic [3:0]  o_byte_en;
  logic [4:0]  o_rd_addr;
  logic [1:0]  o_mem_width;
  logic [NB_CNT-1:0] o_retired_count;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_register #(.NB(32), .NB_REG(5), .NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_rt_data(rt_data),
    .i_rd_addr(rd_addr), .i_pc_plus4(pc_plus4), .i_branch_target(branch_target),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_reg_write(reg_write),
    .i_mem_to_reg(mem_to_reg), .i_branch_eq(branch_eq), .i_branch_ne(branch_ne),
    .i_mem_width(mem_width), .i_mem_unsigned(mem_unsigned), .i_halt(halt),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_byte_en(o_byte_en), .o_rd_addr(o_rd_addr), .o_pc_plus4(o_pc_plus4),
    .o_branch_target(o_branch_target), .o_branch_taken(o_branch_taken),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_mem_width(o_mem_width),
    .o_mem_unsigned(o_mem_unsigned), .o_misaligned(o_misaligned),
    .o_halted(o_halted), .o_retired_count(o_retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: what the MEM stage should hold
  // --------------------------------------------------------------------------
  typedef struct {
    logic        valid;
    logic [31:0] alu, sd, pc, bt;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic        taken, mr, mw, rw, m2r, uns, mis, halted;
    logic [1:0]  w;
    int          cnt;
  } exp_t;

  exp_t m;

  function automatic exp_t bubble(exp_t s);
    exp_t b;
    b = '{valid: 1'b0, alu: 32'd0, sd: 32'd0, pc: 32'd0, bt: 32'd0, be: 4'd0,
          rd: 5'd0, taken: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, m2r: 1'b0,
          uns: 1'b0, mis: 1'b0, halted: s.halted, w: 2'd0, cnt: s.cnt};
    return b;
  endfunction

  function automatic exp_t model_next(exp_t s);
    exp_t n;
    int   a;
    bit   memop, mis;
    if (flush) return bubble(s);
    if (stall) return s;
    if (s.halted || !valid) return bubble(s);
    a     = int'(alu_result[1:0]);
    memop = mem_read || mem_write;
    n     = s;
    n.valid = 1'b1;
    n.alu   = alu_result;
    n.rd    = rd_addr;
    n.pc    = pc_plus4;
    n.bt    = branch_target;
    n.w     = mem_width;
    n.uns   = mem_unsigned;
    n.m2r   = mem_to_reg;
    // Lane replication expressed as multiplication by a lane pattern
    if (mem_width == 2'd0)      n.sd = 32'(rt_data[7:0])  * 32'h0101_0101;
    else if (mem_width == 2'd1) n.sd = 32'(rt_data[15:0]) * 32'h0001_0001;
    else                        n.sd = rt_data;
    if (!memop)                 n.be = 4'd0;
    else if (mem_width == 2'd0) n.be = 4'(1 << a);
    else if (mem_width == 2'd1) n.be = 4'(3 << (a & 2));
    else                        n.be = 4'hF;
    if (mem_width == 2'd0)      mis = 1'b0;
    else if (mem_width == 2'd1) mis = memop && (a % 2 != 0);
    else                        mis = memop && (a != 0);
    n.mis = mis;
    n.mr  = mem_read  && !mis;
    n.mw  = mem_write && !mis && !halt;
    n.rw  = reg_write && !mis && !halt;
    if (branch_eq && branch_ne) n.taken = 1'b0;
    else n.taken = (branch_eq && alu_zero) || (branch_ne && !alu_zero);
    if (halt) n.halted = 1'b1;
    else if (s.cnt < CNT_MAX) n.cnt = s.cnt + 1;
    return n;
  endfunction

  function automatic exp_t model_reset();
    exp_t z;
    z.halted = 1'b0;
    z.cnt    = 0;
    return bubble(z);
  endfunction

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".valid"},   64'(o_valid),         64'(m.valid));
    check_eq({ctx, ".alu"},     64'(o_alu_result),    64'(m.alu));
    check_eq({ctx, ".sdata"},   64'(o_store_data),    64'(m.sd));
    check_eq({ctx, ".be"},      64'(o_byte_en),       64'(m.be));
    check_eq({ctx, ".rd"},      64'(o_rd_addr),       64'(m.rd));
    check_eq({ctx, ".pc4"},     64'(o_pc_plus4),      64'(m.pc));
    check_eq({ctx, ".bt"},      64'(o_branch_target), 64'(m.bt));
    check_eq({ctx, ".taken"},   64'(o_branch_taken),  64'(m.taken));
    check_eq({ctx, ".mr"},      64'(o_mem_read),      64'(m.mr));
    check_eq({ctx, ".mw"},      64'(o_mem_write),     64'(m.mw));
    check_eq({ctx, ".rw"},      64'(o_reg_write),     64'(m.rw));
    check_eq({ctx, ".m2r"},     64'(o_mem_to_reg),    64'(m.m2r));
    check_eq({ctx, ".width"},   64'(o_mem_width),     64'(m.w));
    check_eq({ctx, ".uns"},     64'(o_mem_unsigned),  64'(m.uns));
    check_eq({ctx, ".mis"},     64'(o_misaligned),    64'(m.mis));
    check_eq({ctx, ".halted"},  64'(o_halted),        64'(m.halted));
    check_eq({ctx, ".cnt"},     64'(o_retired_count), 64'(m.cnt));
  endtask

  // One clock: model advances on the edge, outputs checked 1ns after it.
  task automatic step(input string ctx);
    exp_t nxt;
    nxt = rst_n ? model_next(m) : model_reset();
    @(posedge clk);
    #1;
    m = nxt;
    check_all(ctx);
  endtask

  task automatic rand_fields();
    alu_result    = $urandom;
    alu_zero      = 1'($urandom_range(0, 1));
    rt_data       = $urandom;
    rd_addr       = 5'($urandom);
    pc_plus4      = $urandom;
    branch_target = $urandom;
    mem_read      = ($urandom_range(0, 3) == 0);
    mem_write     = ($urandom_range(0, 3) == 0);
    reg_write     = 1'($urandom_range(0, 1));
    mem_to_reg    = 1'($urandom_range(0, 1));
    branch_eq     = ($urandom_range(0, 3) == 0);
    branch_ne     = ($urandom_range(0, 3) == 0);
    mem_width     = 2'($urandom);
    mem_unsigned  = 1'($urandom_range(0, 1));
  endtask

  task automatic plain_op();
    rand_fields();
    valid = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0;
  endtask

  int snap_cnt;

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b0; halt = 1'b0;
    rand_fields();
    #1 rst_n = 1'b0;
    #1;
    m = model_reset();
    check_all("reset");
    step("reset_hold");
    #2 rst_n = 1'b1;

    // Store-word to a misaligned address is suppressed; store-byte is fine.
    plain_op();
    mem_read = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
    mem_width = 2'b10; alu_result = 32'h0000_1003; rt_data = 32'h1122_33DD;
    step("sw_mis");
    check_eq("sw_mis_flag", 64'(o_misaligned), 64'd1);
    check_eq("sw_mis_mw",   64'(o_mem_write),  64'd0);
    check_eq("sw_mis_vld",  64'(o_valid),      64'd1);
    mem_width = 2'b00;
    step("sb");
    check_eq("sb_be",    64'(o_byte_en),    64'h8);
    check_eq("sb_sdata", 64'(o_store_data), 64'hDDDD_DDDD);

    // BNE with zero clear is taken; same instruction flushed is not.
    plain_op();
    branch_eq = 1'b0; branch_ne = 1'b1; alu_zero = 1'b0;
    step("bne");
    check_eq("bne_taken", 64'(o_branch_taken), 64'd1);
    flush = 1'b1;
    step("bne_flush");
    check_eq("bne_flush_taken", 64'(o_branch_taken), 64'd0);
    check_eq("bne_flush_valid", 64'(o_valid),        64'd0);

    // Stall freezes everything even while inputs keep changing.
    plain_op();
    step("pre_stall");
    snap_cnt = m.cnt;
    for (int i = 0; i < 3; i++) begin
      plain_op();
      stall = 1'b1;
      step("stall");
    end
    check_eq("stall_cnt", 64'(o_retired_count), 64'(snap_cnt));
    flush = 1'b1;
    step("stall_flush");
    check_eq("stall_flush_valid", 64'(o_valid), 64'd0);

    // Random mix of valid/invalid, stall and flush; drives the counter to saturation.
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      halt  = 1'b0;
      step("rand");
    end
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      plain_op();
      step("sat");
    end
    check_eq("sat_cnt", 64'(o_retired_count), 64'(CNT_MAX));

    // Asynchronous reset mid-stream with valid data applied.
    plain_op();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m = model_reset();
    check_all("async_rst");
    check_eq("async_rst_cnt", 64'(o_retired_count), 64'd0);
    step("rst_held");
    #2 rst_n = 1'b1;

    // Five instructions, HALT, then further instructions are all bubbles.
    for (int i = 0; i < 5; i++) begin
      plain_op();
      step("pre_halt");
    end
    plain_op();
    halt = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    step("halt");
    check_eq("halt_flag", 64'(o_halted),  64'd1);
    check_eq("halt_rw",   64'(o_reg_write), 64'd0);
    for (int i = 0; i < 4; i++) begin
      plain_op();
      step("post_halt");
    end
    check_eq("halt_cnt",   64'(o_retired_count), 64'd5);
    check_eq("halt_sticky", 64'(o_halted),       64'd1);
    check_eq("halt_bubble", 64'(o_valid),        64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
